// File: rtl/cfg_load_pkg.sv
// Shared types and helpers for the configuration load sequencer.
//   state_e    : sequencer FSM states
//   nwords()   : number of upstream words needed to cover one bitstream
//   idx_width(): width of an index over n items, never below 1
package cfg_load_pkg;

  typedef enum logic [1:0] {IDLE, FETCH, SHIFT, CHECK} state_e;

  function automatic int unsigned nwords(int unsigned cfg_size, int unsigned word_w);
    return (cfg_size + word_w - 1) / word_w;
  endfunction

  function automatic int unsigned idx_width(int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/cfg_word_serializer.sv
// Parallel-to-serial stage for one config word.
//   clk, rst : clock, synchronous active-high reset
//   load     : capture data and the number of bits to emit (len)
//   shift    : advance one bit (MSB-first)
//   ser_bit  : current output bit (shift register MSB)
//   last     : the bit currently presented is the final one of this word
module cfg_word_serializer #(
  parameter int unsigned WORD_W = 32,
  parameter int unsigned LEN_W  = $clog2(WORD_W + 1)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              load,
  input  logic              shift,
  input  logic [LEN_W-1:0]  len,
  input  logic [WORD_W-1:0] data,
  output logic              ser_bit,
  output logic              last
);

  logic [WORD_W-1:0] shreg_q;
  logic [LEN_W-1:0]  cnt_q;
  logic [LEN_W-1:0]  len_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      shreg_q <= '0;
      cnt_q   <= '0;
      len_q   <= '0;
    end else if (load) begin
      shreg_q <= data;
      cnt_q   <= '0;
      len_q   <= len;
    end else if (shift) begin
      shreg_q <= {shreg_q[WORD_W-2:0], 1'b0};
      cnt_q   <= cnt_q + LEN_W'(1);
    end
  end

  assign ser_bit = shreg_q[WORD_W-1];
  assign last    = (cnt_q + LEN_W'(1)) == len_q;

endmodule

// File: rtl/cfg_load_sequencer.sv
// Sequences configuration bitstream loads into an array of bitstream deserializers.
//   clk, rst    : clock, synchronous active-high reset
//   load_req    : start a load of target load_tgt (sampled only while idle)
//   word_valid/word_data/word_ready : upstream config word stream
//   ser_data    : shared serial bit, MSB of the bitstream first
//   ser_valid   : one-hot stream-valid strobe to the selected target
//   tgt_done    : per-target config-done flags
//   busy        : a load is in progress
//   load_done   : one-cycle pulse, load completed and the target confirmed done
//   load_err    : one-cycle pulse, request rejected or target not done after load
//   loaded      : sticky mask of successfully loaded targets
module cfg_load_sequencer
  import cfg_load_pkg::*;
#(
  parameter int unsigned CFG_SIZE = 100,
  parameter int unsigned WORD_W   = 32,
  parameter int unsigned NUM_TGT  = 4,
  // May be widened beyond the minimum; indices >= NUM_TGT are rejected.
  parameter int unsigned TGT_W    = idx_width(NUM_TGT)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               load_req,
  input  logic [TGT_W-1:0]   load_tgt,
  input  logic               word_valid,
  input  logic [WORD_W-1:0]  word_data,
  output logic               word_ready,
  output logic               ser_data,
  output logic [NUM_TGT-1:0] ser_valid,
  input  logic [NUM_TGT-1:0] tgt_done,
  output logic               busy,
  output logic               load_done,
  output logic               load_err,
  output logic [NUM_TGT-1:0] loaded
);

  localparam int unsigned NW       = nwords(CFG_SIZE, WORD_W);
  localparam int unsigned BIT_W    = $clog2(CFG_SIZE + 1);
  localparam int unsigned WCNT_W   = $clog2(NW + 1);
  localparam int unsigned LEN_W    = $clog2(WORD_W + 1);
  localparam int unsigned LAST_LEN = CFG_SIZE - (NW - 1) * WORD_W;

  state_e             state_q, state_d;
  logic [TGT_W-1:0]   tgt_q, tgt_d;
  logic [BIT_W-1:0]   bit_cnt_q, bit_cnt_d;
  logic [WCNT_W-1:0]  word_cnt_q, word_cnt_d;
  logic [NUM_TGT-1:0] loaded_q, loaded_d;
  logic               load_done_q, done_d;
  logic               load_err_q, err_d;

  logic               ser_load, ser_shift, ser_bit, ser_last;
  logic [LEN_W-1:0]   ser_len;
  logic               req_in_range, req_loaded, sel_done;
  logic [NUM_TGT-1:0] tgt_hot;

  // Index decode done by comparison so out-of-range indices never address the masks.
  always_comb begin
    req_in_range = 1'b0;
    req_loaded   = 1'b0;
    sel_done     = 1'b0;
    tgt_hot      = '0;
    for (int unsigned i = 0; i < NUM_TGT; i++) begin
      if (load_tgt == TGT_W'(i)) begin
        req_in_range = 1'b1;
        req_loaded   = loaded_q[i];
      end
      if (tgt_q == TGT_W'(i)) begin
        sel_done   = tgt_done[i];
        tgt_hot[i] = 1'b1;
      end
    end
  end

  // Final word carries only the remaining bits; its low bits are dropped.
  assign ser_len = (word_cnt_q == WCNT_W'(NW - 1)) ? LEN_W'(LAST_LEN) : LEN_W'(WORD_W);

  always_comb begin
    state_d    = state_q;
    tgt_d      = tgt_q;
    bit_cnt_d  = bit_cnt_q;
    word_cnt_d = word_cnt_q;
    loaded_d   = loaded_q;
    done_d     = 1'b0;
    err_d      = 1'b0;
    word_ready = 1'b0;
    ser_load   = 1'b0;
    ser_shift  = 1'b0;
    case (state_q)
      IDLE: begin
        if (load_req) begin
          // Targets cannot be re-armed without rst, so a reload is an error.
          if (req_in_range && !req_loaded) begin
            tgt_d      = load_tgt;
            bit_cnt_d  = '0;
            word_cnt_d = '0;
            state_d    = FETCH;
          end else begin
            err_d = 1'b1;
          end
        end
      end
      FETCH: begin
        word_ready = 1'b1;
        if (word_valid) begin
          ser_load   = 1'b1;
          word_cnt_d = word_cnt_q + WCNT_W'(1);
          state_d    = SHIFT;
        end
      end
      SHIFT: begin
        ser_shift = 1'b1;
        bit_cnt_d = bit_cnt_q + BIT_W'(1);
        if (bit_cnt_q == BIT_W'(CFG_SIZE - 1)) begin
          state_d = CHECK;
        end else if (ser_last) begin
          state_d = FETCH;
        end
      end
      CHECK: begin
        if (sel_done) begin
          done_d   = 1'b1;
          loaded_d = loaded_q | tgt_hot;
        end else begin
          err_d = 1'b1;
        end
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      tgt_q       <= '0;
      bit_cnt_q   <= '0;
      word_cnt_q  <= '0;
      loaded_q    <= '0;
      load_done_q <= 1'b0;
      load_err_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      tgt_q       <= tgt_d;
      bit_cnt_q   <= bit_cnt_d;
      word_cnt_q  <= word_cnt_d;
      loaded_q    <= loaded_d;
      load_done_q <= done_d;
      load_err_q  <= err_d;
    end
  end

  cfg_word_serializer #(
    .WORD_W (WORD_W),
    .LEN_W  (LEN_W)
  ) u_ser (
    .clk     (clk),
    .rst     (rst),
    .load    (ser_load),
    .shift   (ser_shift),
    .len     (ser_len),
    .data    (word_data),
    .ser_bit (ser_bit),
    .last    (ser_last)
  );

  assign busy      = (state_q != IDLE);
  assign ser_valid = (state_q == SHIFT) ? tgt_hot : '0;
  assign ser_data  = (state_q == SHIFT) & ser_bit;
  assign load_done = load_done_q;
  assign load_err  = load_err_q;
  assign loaded    = loaded_q;

endmodule

// File: tb/tb_cfg_load_sequencer.sv
module tb_cfg_load_sequencer;

  localparam int CFG_SIZE = 100;
  localparam int WORD_W   = 32;
  localparam int NUM_TGT  = 4;
  localparam int TGT_W    = 3;
  localparam int NW       = 4;
  localparam int LATENCY  = 1 + CFG_SIZE + NW + 1;

  localparam int OUT_TIMEOUT = 0;
  localparam int OUT_DONE    = 1;
  localparam int OUT_ERR     = 2;
  localparam int OUT_ABORT   = 3;

  logic               clk = 1'b0;
  logic               rst = 1'b1;
  logic               load_req = 1'b0;
  logic [TGT_W-1:0]   load_tgt = '0;
  logic               word_valid = 1'b0;
  logic [WORD_W-1:0]  word_data = '0;
  logic               word_ready;
  logic               ser_data;
  logic [NUM_TGT-1:0] ser_valid;
  logic [NUM_TGT-1:0] tgt_done;
  logic               busy, load_done, load_err;
  logic [NUM_TGT-1:0] loaded;

  cfg_load_sequencer #(
    .CFG_SIZE (CFG_SIZE),
    .WORD_W   (WORD_W),
    .NUM_TGT  (NUM_TGT),
    .TGT_W    (TGT_W)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .load_req   (load_req),
    .load_tgt   (load_tgt),
    .word_valid (word_valid),
    .word_data  (word_data),
    .word_ready (word_ready),
    .ser_data   (ser_data),
    .ser_valid  (ser_valid),
    .tgt_done   (tgt_done),
    .busy       (busy),
    .load_done  (load_done),
    .load_err   (load_err),
    .loaded     (loaded)
  );

  always #5 clk = ~clk;

  // Deserializer models: shift left on strobe, done once CFG_SIZE bits arrived.
  logic [CFG_SIZE-1:0] tsr [NUM_TGT];
  int                  tcnt [NUM_TGT];
  logic [NUM_TGT-1:0]  stuck = '0;

  always @(posedge clk) begin
    for (int i = 0; i < NUM_TGT; i++) begin
      if (rst) begin
        tsr[i]  <= '0;
        tcnt[i] <= 0;
      end else if (ser_valid[i] && tcnt[i] < CFG_SIZE) begin
        tsr[i]  <= {tsr[i][CFG_SIZE-2:0], ser_data};
        tcnt[i] <= tcnt[i] + 1;
      end
    end
  end

  always_comb begin
    tgt_done = '0;
    for (int i = 0; i < NUM_TGT; i++) tgt_done[i] = (tcnt[i] == CFG_SIZE) && !stuck[i];
  end

  int tests = 0;
  int fails = 0;
  logic [WORD_W-1:0] words [NW];
  logic              exp_bits [$];
  int                exp_out [$];
  logic [127:0]      cat;
  logic [CFG_SIZE-1:0] exp_par;

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Issue one load and run it to completion (or abort after abort_at bits).
  task automatic do_load(input int tgt, input bit gaps, input int abort_at,
                         output int lat, output int nbits, output int bad,
                         output int nready, output int outcome);
    int widx, remaining, n;
    widx = 0; remaining = CFG_SIZE; nbits = 0; bad = 0; nready = 0;
    outcome = OUT_TIMEOUT; lat = 0;
    exp_bits.delete();
    @(negedge clk);
    load_req = 1'b1;
    load_tgt = TGT_W'(tgt);
    @(negedge clk);
    load_req = 1'b0;
    for (int cyc = 1; cyc <= 2000; cyc++) begin
      if (cyc > 1) @(negedge clk);
      if (load_done && load_err) bad++;
      if (word_ready) nready++;
      if (ser_valid != 0) begin
        nbits++;
        if (ser_valid != (4'b0001 << tgt) || word_ready) bad++;
        if (exp_bits.size() == 0) bad++;
        else if (ser_data !== exp_bits.pop_front()) bad++;
      end
      if (load_done || load_err) begin
        outcome = load_done ? OUT_DONE : OUT_ERR;
        lat = cyc;
        break;
      end
      if (abort_at > 0 && nbits == abort_at) begin
        outcome = OUT_ABORT;
        break;
      end
      word_valid = (widx < NW) && (!gaps || $urandom_range(1, 0) == 1);
      word_data  = word_valid ? words[widx] : WORD_W'($urandom);
      if (word_valid && word_ready) begin
        n = (remaining < WORD_W) ? remaining : WORD_W;
        for (int j = 0; j < n; j++) exp_bits.push_back(words[widx][WORD_W-1-j]);
        remaining -= n;
        widx++;
      end
    end
    word_valid = 1'b0;
  endtask

  // A rejected request must leave the sequencer quiet for a few cycles.
  task automatic quiet_after_err(input string tag);
    int noise;
    noise = 0;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      if (busy || word_ready || ser_valid != 0 || load_err || load_done) noise++;
    end
    check(tag, 128'(noise), 128'(0));
  endtask

  int lat, nbits, bad, nready, outcome;

  initial begin
    words[0] = 32'hDEADBEEF;
    words[1] = 32'h01234567;
    words[2] = 32'h89ABCDEF;
    words[3] = 32'hF0000000;
    cat      = {words[0], words[1], words[2], words[3]};
    exp_par  = cat[127:128-CFG_SIZE];

    repeat (3) @(negedge clk);
    rst = 1'b0;
    check("rst_busy", 128'(busy), 128'(0));
    check("rst_word_ready", 128'(word_ready), 128'(0));
    check("rst_ser", 128'({ser_valid, ser_data}), 128'(0));
    check("rst_pulses", 128'({load_done, load_err}), 128'(0));
    check("rst_loaded", 128'(loaded), 128'(0));

    // 1: target 2, word_valid always high
    exp_out.push_back(OUT_DONE);
    do_load(2, 1'b0, 0, lat, nbits, bad, nready, outcome);
    check("t1_outcome", 128'(outcome), 128'(exp_out.pop_front()));
    check("t1_latency", 128'(lat), 128'(LATENCY));
    check("t1_bits", 128'(nbits), 128'(CFG_SIZE));
    check("t1_stream", 128'(bad), 128'(0));
    check("t1_parout", 128'(tsr[2]), 128'(exp_par));
    check("t1_loaded", 128'(loaded), 128'(4'b0100));
    @(negedge clk);
    check("t1_pulse_width", 128'({load_done, busy}), 128'(0));

    // 2: target 0 with random word_valid gaps
    exp_out.push_back(OUT_DONE);
    do_load(0, 1'b1, 0, lat, nbits, bad, nready, outcome);
    check("t2_outcome", 128'(outcome), 128'(exp_out.pop_front()));
    check("t2_bits", 128'(nbits), 128'(CFG_SIZE));
    check("t2_stream", 128'(bad), 128'(0));
    check("t2_parout", 128'(tsr[0]), 128'(exp_par));
    check("t2_untouched", 128'({tcnt[1] == 0, tcnt[3] == 0}), 128'(2'b11));
    check("t2_loaded", 128'(loaded), 128'(4'b0101));

    // 3: reload of target 2 is rejected
    exp_out.push_back(OUT_ERR);
    word_valid = 1'b1;
    word_data  = words[0];
    do_load(2, 1'b0, 0, lat, nbits, bad, nready, outcome);
    check("t3_outcome", 128'(outcome), 128'(exp_out.pop_front()));
    check("t3_latency", 128'(lat), 128'(1));
    check("t3_no_traffic", 128'({nbits, nready}), 128'(0));
    quiet_after_err("t3_quiet");

    // 4: out-of-range target index
    exp_out.push_back(OUT_ERR);
    do_load(5, 1'b0, 0, lat, nbits, bad, nready, outcome);
    check("t4_outcome", 128'(outcome), 128'(exp_out.pop_front()));
    check("t4_latency", 128'(lat), 128'(1));
    check("t4_no_traffic", 128'({nbits, nready}), 128'(0));
    quiet_after_err("t4_quiet");

    // 5: target 1 never reports done
    stuck = 4'b0010;
    exp_out.push_back(OUT_ERR);
    do_load(1, 1'b0, 0, lat, nbits, bad, nready, outcome);
    check("t5_outcome", 128'(outcome), 128'(exp_out.pop_front()));
    check("t5_latency", 128'(lat), 128'(LATENCY));
    check("t5_bits", 128'(nbits), 128'(CFG_SIZE));
    check("t5_stream", 128'(bad), 128'(0));
    check("t5_loaded", 128'(loaded), 128'(4'b0101));
    stuck = '0;

    // 6: reset after 40 bits, then a fresh load
    exp_out.push_back(OUT_ABORT);
    do_load(3, 1'b0, 40, lat, nbits, bad, nready, outcome);
    check("t6_abort", 128'(outcome), 128'(exp_out.pop_front()));
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("t6_rst_busy", 128'(busy), 128'(0));
    check("t6_rst_loaded", 128'(loaded), 128'(0));
    check("t6_rst_ser_valid", 128'(ser_valid), 128'(0));
    exp_out.push_back(OUT_DONE);
    do_load(3, 1'b0, 0, lat, nbits, bad, nready, outcome);
    check("t6_outcome", 128'(outcome), 128'(exp_out.pop_front()));
    check("t6_latency", 128'(lat), 128'(LATENCY));
    check("t6_stream", 128'(bad), 128'(0));
    check("t6_parout", 128'(tsr[3]), 128'(exp_par));
    check("t6_loaded", 128'(loaded), 128'(4'b1000));

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
